// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the receive path.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    XFER,
    ACK,
    WAITREL
  } tx_state_t;

  localparam int unsigned PS2_DATA_BITS = 8;
  localparam int unsigned PS2_STOP_IDX  = 9;

  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer plus falling-edge detect for one PS/2 line.
module ps2_line_sync (
  input  logic sysclk,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic fe
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], line};
    prev_d = sync_q[1];
  end

  // Lines idle high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[1];
  assign fe    = prev_q & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request, shift byte/parity/stop, check ack.
// Optional watchdog enabled by defining PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES   = 10,
  parameter int unsigned REQ_SETUP_CYCLES = 2,
  parameter int unsigned TIMEOUT_CYCLES   = 1500
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       clk,
  input  logic       dat,
  output logic       clk_pull,
  output logic       dat_pull,
  input  logic [7:0] word,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned TmrMax = (INHIBIT_CYCLES > REQ_SETUP_CYCLES) ?
                                   INHIBIT_CYCLES : REQ_SETUP_CYCLES;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);

  logic clk_s, clk_fe, dat_s, unused_dat_fe;

  ps2_line_sync u_clk_sync (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .line  (clk),
    .level (clk_s),
    .fe    (clk_fe)
  );

  ps2_line_sync u_dat_sync (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .line  (dat),
    .level (dat_s),
    .fe    (unused_dat_fe)
  );

  tx_state_t           state_q, state_d;
  logic [7:0]          shift_q, shift_d;
  logic                parity_q, parity_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [TmrW-1:0]     tmr_q, tmr_d;
  logic                clk_pull_q, clk_pull_d;
  logic                dat_pull_q, dat_pull_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] wd_q, wd_d;
`else
  localparam int unsigned UnusedTimeout = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    clk_pull_d = clk_pull_q;
    dat_pull_d = dat_pull_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        clk_pull_d = 1'b0;
        dat_pull_d = 1'b0;
        if (start) begin
          shift_d    = word;
          parity_d   = odd_parity(word);
          cnt_d      = '0;
          tmr_d      = '0;
          clk_pull_d = 1'b1;
          state_d    = INHIBIT;
        end
      end
      INHIBIT: begin
        if (tmr_q == TmrW'(INHIBIT_CYCLES - 1)) begin
          tmr_d      = '0;
          dat_pull_d = 1'b1;
          state_d    = REQ;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      REQ: begin
        if (tmr_q == TmrW'(REQ_SETUP_CYCLES - 1)) begin
          tmr_d      = '0;
          clk_pull_d = 1'b0;
          cnt_d      = '0;
          state_d    = XFER;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      XFER: begin
        // The start bit stays on the line until the device's first fall.
        if (clk_fe) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q < 4'(PS2_DATA_BITS)) begin
            dat_pull_d = ~shift_q[0];
            shift_d    = {1'b0, shift_q[7:1]};
          end else if (cnt_q == 4'(PS2_DATA_BITS)) begin
            dat_pull_d = ~parity_q;
          end else if (cnt_q == 4'(PS2_STOP_IDX)) begin
            dat_pull_d = 1'b0;
            state_d    = ACK;
          end
        end
      end
      ACK: begin
        if (clk_fe) begin
          if (!dat_s) begin
            state_d = WAITREL;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAITREL: begin
        if (clk_s && dat_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        clk_pull_d = 1'b0;
        dat_pull_d = 1'b0;
        state_d    = IDLE;
      end
    endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
    wd_d = '0;
    if (state_q == XFER || state_q == ACK || state_q == WAITREL) begin
      if (clk_fe) begin
        wd_d = '0;
      end else if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
        // Device went quiet: abandon the frame and free the lines.
        wd_d       = '0;
        done_d     = 1'b0;
        err_d      = 1'b1;
        clk_pull_d = 1'b0;
        dat_pull_d = 1'b0;
        state_d    = IDLE;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      clk_pull_q <= 1'b0;
      dat_pull_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      clk_pull_q <= clk_pull_d;
      dat_pull_q <= dat_pull_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

`ifdef PS2_HOST_TX_TIMEOUT_EN
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  assign clk_pull = clk_pull_q;
  assign dat_pull = dat_pull_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device on wired-AND lines, frame scoreboard.
module tb_ps2_host_tx;

  localparam int TimeoutCycles = 1500;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic [7:0] word   = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       clk_line, dat_line;
  logic       clk_pull, dat_pull, busy, done, err;

  assign clk_line = dev_clk & ~clk_pull;
  assign dat_line = dev_dat & ~dat_pull;

  ps2_host_tx dut (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .clk     (clk_line),
    .dat     (dat_line),
    .clk_pull(clk_pull),
    .dat_pull(dat_pull),
    .word    (word),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [7:0] word;
    bit         ack;
    bit         exp_parity;
    int         exp_done;
    int         exp_err;
  } vec_t;

  typedef struct {
    logic [10:0] frame;
    int          exp_done;
    int          exp_err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int done_cnt = 0, err_cnt = 0, inh_len = 0, req_len = 0, bad_busy = 0, both = 0;

  always @(negedge sysclk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (clk_pull && !dat_pull) inh_len++;
      if (clk_pull && dat_pull) req_len++;
      if ((done || err) && busy) bad_busy++;
      if (done && err) both++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] model_frame(input logic [7:0] w);
    int ones = 0;
    for (int k = 0; k < 8; k++) if (w[k]) ones++;
    return {1'b1, ((ones % 2) == 0), w, 1'b0};
  endfunction

  task automatic wait_request(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (clk_pull && dat_pull) begin
        ok = 1'b1;
        break;
      end
      @(negedge sysclk);
    end
    if (!ok) return;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (!clk_pull) begin
        ok = 1'b1;
        break;
      end
      @(negedge sysclk);
    end
  endtask

  // One device clock period: sample data while high, then fall and rise.
  task automatic dev_clock(input int i, input bit ack, output logic b);
    repeat (10) @(negedge sysclk);
    b = dat_line;
    if (i == 10) begin
      if (ack) dev_dat = 1'b0;
      repeat (2) @(negedge sysclk);
    end
    dev_clk = 1'b0;
    repeat (10) @(negedge sysclk);
    dev_clk = 1'b1;
    if (i == 10) begin
      repeat (3) @(negedge sysclk);
      dev_dat = 1'b1;
    end
  endtask

  task automatic send_start(input logic [7:0] w);
    @(negedge sysclk);
    word  = w;
    start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
    word  = 8'h00;
  endtask

  task automatic run_txn(input logic [7:0] w, input bit ack, input bit exp_par,
                         input int ed, input int ee, input bit poke);
    exp_t        e, got;
    logic [10:0] fr;
    logic        b;
    bit          ok;
    int          d0, e0, i0, r0;
    d0 = done_cnt; e0 = err_cnt; i0 = inh_len; r0 = req_len;
    e.frame = model_frame(w);
    e.exp_done = ed;
    e.exp_err = ee;
    sb.push_back(e);
    send_start(w);
    check("busy_after_start", busy, 1);
    wait_request(ok);
    got = sb.pop_front();
    if (!ok) begin
      check("request_seen", 0, 1);
      return;
    end
    fr = '0;
    for (int i = 0; i < 11; i++) begin
      dev_clock(i, ack, b);
      fr[i] = b;
      if (poke && i == 3) begin
        word  = 8'hFF;
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
        word  = 8'h00;
      end
    end
    for (int k = 0; k < 200 && busy; k++) @(negedge sysclk);
    check("busy_released", busy, 0);
    repeat (3) @(negedge sysclk);
    check("inhibit_cycles", inh_len - i0, 10);
    check("req_setup_cycles", req_len - r0, 2);
    check("frame_bits", fr, got.frame);
    check("parity_bit", fr[9], exp_par);
    check("done_pulses", done_cnt - d0, got.exp_done);
    check("err_pulses", err_cnt - e0, got.exp_err);
    check("clk_pull_idle", clk_pull, 0);
    check("dat_pull_idle", dat_pull, 0);
  endtask

  vec_t vecs[5];

  initial begin
    logic b;
    bit   ok;
    int   d0, e0;

    vecs[0] = '{word: 8'hED, ack: 1'b1, exp_parity: 1'b1, exp_done: 1, exp_err: 0};
    vecs[1] = '{word: 8'h00, ack: 1'b1, exp_parity: 1'b1, exp_done: 1, exp_err: 0};
    vecs[2] = '{word: 8'h01, ack: 1'b1, exp_parity: 1'b0, exp_done: 1, exp_err: 0};
    vecs[3] = '{word: 8'hA5, ack: 1'b0, exp_parity: 1'b1, exp_done: 0, exp_err: 1};
    vecs[4] = '{word: 8'h3C, ack: 1'b1, exp_parity: 1'b1, exp_done: 1, exp_err: 0};

    repeat (3) @(negedge sysclk);
    check("rst_clk_pull", clk_pull, 0);
    check("rst_dat_pull", dat_pull, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge sysclk);

    foreach (vecs[n]) begin
      run_txn(vecs[n].word, vecs[n].ack, vecs[n].exp_parity, vecs[n].exp_done,
              vecs[n].exp_err, 1'b0);
    end

    // Start during XFER must be ignored.
    run_txn(8'hED, 1'b1, 1'b1, 1, 0, 1'b1);

    // Reset mid-transfer: lines released at once, no completion pulses.
    d0 = done_cnt; e0 = err_cnt;
    send_start(8'hED);
    wait_request(ok);
    check("rst_seq_request", ok, 1);
    for (int i = 0; i < 5; i++) dev_clock(i, 1'b1, b);
    check("pre_reset_dat_pull", dat_pull, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_clk_pull", clk_pull, 0);
    check("async_rst_dat_pull", dat_pull, 0);
    check("async_rst_busy", busy, 0);
    repeat (5) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (3) @(negedge sysclk);
    check("rst_seq_done", done_cnt - d0, 0);
    check("rst_seq_err", err_cnt - e0, 0);
    run_txn(8'h5A, 1'b1, 1'b1, 1, 0, 1'b0);

`ifdef PS2_HOST_TX_TIMEOUT_EN
    begin
      int n;
      d0 = done_cnt; e0 = err_cnt;
      send_start(8'hC3);
      wait_request(ok);
      check("to_request", ok, 1);
      dev_clock(0, 1'b1, b);
      dev_clock(1, 1'b1, b);
      repeat (10) @(negedge sysclk);
      dev_clk = 1'b0;
      n = 0;
      while (!err && n < TimeoutCycles + 50) begin
        @(negedge sysclk);
        n++;
      end
      check("timeout_latency", n, TimeoutCycles + 3);
      check("timeout_clk_pull", clk_pull, 0);
      check("timeout_dat_pull", dat_pull, 0);
      dev_clk = 1'b1;
      repeat (3) @(negedge sysclk);
      check("timeout_err", err_cnt - e0, 1);
      check("timeout_done", done_cnt - d0, 0);
    end
`endif

    check("busy_with_pulse", bad_busy, 0);
    check("done_err_exclusive", both, 0);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got still running, required finished");
    $fatal(1, "global timeout");
  end

endmodule
